// File: rtl/enigma_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enigma_pkg
// Description : Shared widths, port enumeration and tag helper for the
//               enigma two-port QoS arbiter.
//               A tag is {port_bit, source_id}; port A is 0 and port B is 1.
// Revision    : 1.0 - initial release
// ============================================================================
package enigma_pkg;

  localparam int DATA_W   = 128;
  localparam int SRC_ID_W = 5;
  localparam int QOS_W    = 2;
  localparam int TAG_W    = SRC_ID_W + 1;
  localparam int CNT_W    = TAG_W + 1;
  localparam int SB_DEPTH = 1 << TAG_W;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef logic [TAG_W-1:0] tag_t;

  function automatic tag_t make_tag(port_e port, logic [SRC_ID_W-1:0] id);
    return {port == PORT_B, id};
  endfunction

endpackage
`default_nettype wire

// File: rtl/enigma_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : enigma_arb_if
// Description : Bundle of every request/response signal around the arbiter.
//               Port A/B request: payload_x, id_x, qos_x, valid_x, ready_x.
//               Port C request  : valid_c, payload_c, id_c, qos_c, ready_c.
//               Port C feedback : conflict_c, release_c, releaseid_c.
//               Status          : outstanding_cnt, rel_err.
//               Modport slave  = arbiter side; modport master = environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface enigma_arb_if;
  import enigma_pkg::*;

  logic [DATA_W-1:0]   payload_a;
  logic [SRC_ID_W-1:0] id_a;
  logic [QOS_W-1:0]    qos_a;
  logic                valid_a;
  logic                ready_a;

  logic [DATA_W-1:0]   payload_b;
  logic [SRC_ID_W-1:0] id_b;
  logic [QOS_W-1:0]    qos_b;
  logic                valid_b;
  logic                ready_b;

  logic                valid_c;
  logic [DATA_W-1:0]   payload_c;
  logic [TAG_W-1:0]    id_c;
  logic [QOS_W-1:0]    qos_c;
  logic                ready_c;
  logic                conflict_c;
  logic                release_c;
  logic [TAG_W-1:0]    releaseid_c;

  logic [CNT_W-1:0]    outstanding_cnt;
  logic                rel_err;

  modport slave (
    input  payload_a, id_a, qos_a, valid_a,
    output ready_a,
    input  payload_b, id_b, qos_b, valid_b,
    output ready_b,
    output valid_c, payload_c, id_c, qos_c,
    input  ready_c, conflict_c, release_c, releaseid_c,
    output outstanding_cnt, rel_err
  );

  modport master (
    output payload_a, id_a, qos_a, valid_a,
    input  ready_a,
    output payload_b, id_b, qos_b, valid_b,
    input  ready_b,
    input  valid_c, payload_c, id_c, qos_c,
    output ready_c, conflict_c, release_c, releaseid_c,
    input  outstanding_cnt, rel_err
  );

endinterface
`default_nettype wire

// File: rtl/enigma_arb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : enigma_arb_scoreboard
// Description : One bit per tag marking it outstanding, plus the outstanding
//               counter and a sticky error flag for releases of idle tags.
//   clk, rst_n          : clock, asynchronous active-low reset
//   set_i/set_tag_i     : mark a tag outstanding (accept)
//   rel_i/rel_tag_i     : retire a tag
//   lookup_{a,b}_tag_i  : tags to query; busy_{a,b}_o are registered bits
//   cnt_o               : number of outstanding tags
//   rel_err_o           : sticky, release of a tag that was not outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module enigma_arb_scoreboard
  import enigma_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       set_i,
  input  wire tag_t       set_tag_i,
  input  wire logic       rel_i,
  input  wire tag_t       rel_tag_i,
  input  wire tag_t       lookup_a_tag_i,
  input  wire tag_t       lookup_b_tag_i,
  output logic            busy_a_o,
  output logic            busy_b_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic            rel_err_o
);

  logic [SB_DEPTH-1:0] sb_q, sb_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rel_err_q, rel_err_d;
  logic                rel_hit;

  assign rel_hit = rel_i && sb_q[rel_tag_i];

  // The arbiter never sets a tag whose registered bit is 1, so a set and a
  // valid release can never target the same bit in one cycle.
  always_comb begin
    sb_d = sb_q;
    if (rel_hit) sb_d[rel_tag_i] = 1'b0;
    if (set_i)   sb_d[set_tag_i] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({set_i, rel_hit})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  assign rel_err_d = rel_err_q | (rel_i & ~sb_q[rel_tag_i]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q      <= '0;
      cnt_q     <= '0;
      rel_err_q <= 1'b0;
    end else begin
      sb_q      <= sb_d;
      cnt_q     <= cnt_d;
      rel_err_q <= rel_err_d;
    end
  end

  assign busy_a_o  = sb_q[lookup_a_tag_i];
  assign busy_b_o  = sb_q[lookup_b_tag_i];
  assign cnt_o     = cnt_q;
  assign rel_err_o = rel_err_q;

endmodule
`default_nettype wire

// File: rtl/enigma_arb.sv
`default_nettype none
// ============================================================================
// Module      : enigma_arb
// Description : Two-port QoS arbiter merging requesters A and B onto the
//               enigma buffer port C through a registered output stage.
//               Tracks outstanding tags so no tag is issued twice before its
//               release.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : enigma_arb_if.slave (ports A, B, C and status)
// Optional    : ENIGMA_ARB_AGING_EN adds per-port wait counters; a port that
//               has lost for STARVE_LIMIT cycles overrides QoS.
// Revision    : 1.0 - initial release
// ============================================================================
module enigma_arb
  import enigma_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 64
`ifdef ENIGMA_ARB_AGING_EN
  , parameter int STARVE_LIMIT  = 15
`endif
) (
  input wire logic   clk,
  input wire logic   rst_n,
  enigma_arb_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  tag_t             tag_a, tag_b, accept_tag;
  logic             busy_a, busy_b;
  logic [CNT_W-1:0] cnt;
  logic             rel_err;
  logic             can_accept, elig_a, elig_b;
  logic             pick_b, grant_a, grant_b, accept;

  logic              valid_c_q;
  logic [DATA_W-1:0] payload_c_q;
  tag_t              id_c_q;
  logic [QOS_W-1:0]  qos_c_q;
  port_e             rr_q;

  assign tag_a = make_tag(PORT_A, bus.id_a);
  assign tag_b = make_tag(PORT_B, bus.id_b);

  // Shared eligibility: no hazard, room for another tag, output stage free.
  assign can_accept = !bus.conflict_c && (cnt < MAX_CNT) &&
                      (!valid_c_q || bus.ready_c);
  assign elig_a = bus.valid_a && !busy_a && can_accept;
  assign elig_b = bus.valid_b && !busy_b && can_accept;

`ifdef ENIGMA_ARB_AGING_EN
  localparam int WAIT_W = ($clog2(STARVE_LIMIT + 1) > 4) ?
                          $clog2(STARVE_LIMIT + 1) : 4;
  localparam logic [WAIT_W-1:0] STARVE_CNT = WAIT_W'(STARVE_LIMIT);

  logic [WAIT_W-1:0] wait_a_q, wait_a_d, wait_b_q, wait_b_d;
  logic              starve_a, starve_b;

  assign starve_a = wait_a_q >= STARVE_CNT;
  assign starve_b = wait_b_q >= STARVE_CNT;

  // Count only cycles where the port could have gone but lost.
  always_comb begin
    wait_a_d = wait_a_q;
    wait_b_d = wait_b_q;
    if (!bus.valid_a || grant_a)          wait_a_d = '0;
    else if (elig_a && (wait_a_q != '1))  wait_a_d = wait_a_q + WAIT_W'(1);
    if (!bus.valid_b || grant_b)          wait_b_d = '0;
    else if (elig_b && (wait_b_q != '1))  wait_b_d = wait_b_q + WAIT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_a_q <= '0;
      wait_b_q <= '0;
    end else begin
      wait_a_q <= wait_a_d;
      wait_b_q <= wait_b_d;
    end
  end
`endif

  // pick_b decides the winner only when both ports are eligible.
  always_comb begin
    if (bus.qos_a != bus.qos_b) pick_b = bus.qos_b > bus.qos_a;
    else                        pick_b = (rr_q == PORT_B);
`ifdef ENIGMA_ARB_AGING_EN
    if (starve_a != starve_b)   pick_b = starve_b;
`endif
    grant_a = elig_a && (!elig_b || !pick_b);
    grant_b = elig_b && (!elig_a ||  pick_b);
  end

  assign accept     = grant_a || grant_b;
  assign accept_tag = grant_b ? tag_b : tag_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_c_q   <= 1'b0;
      payload_c_q <= '0;
      id_c_q      <= '0;
      qos_c_q     <= '0;
      rr_q        <= PORT_A;
    end else begin
      if (accept) begin
        valid_c_q   <= 1'b1;
        payload_c_q <= grant_b ? bus.payload_b : bus.payload_a;
        id_c_q      <= accept_tag;
        qos_c_q     <= grant_b ? bus.qos_b : bus.qos_a;
        rr_q        <= grant_a ? PORT_B : PORT_A;
      end else if (bus.ready_c) begin
        valid_c_q   <= 1'b0;
      end
    end
  end

  enigma_arb_scoreboard u_sb (
    .clk            (clk),
    .rst_n          (rst_n),
    .set_i          (accept),
    .set_tag_i      (accept_tag),
    .rel_i          (bus.release_c),
    .rel_tag_i      (bus.releaseid_c),
    .lookup_a_tag_i (tag_a),
    .lookup_b_tag_i (tag_b),
    .busy_a_o       (busy_a),
    .busy_b_o       (busy_b),
    .cnt_o          (cnt),
    .rel_err_o      (rel_err)
  );

  assign bus.ready_a         = grant_a;
  assign bus.ready_b         = grant_b;
  assign bus.valid_c         = valid_c_q;
  assign bus.payload_c       = payload_c_q;
  assign bus.id_c            = id_c_q;
  assign bus.qos_c           = qos_c_q;
  assign bus.outstanding_cnt = cnt;
  assign bus.rel_err         = rel_err;

endmodule
`default_nettype wire

// File: tb/tb_enigma_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_enigma_arb
// Description : Self-checking bench for enigma_arb. A negedge monitor keeps a
//               reference scoreboard (outstanding bits, count, rel_err) and a
//               queue of expected port C beats; scenario tasks add directed
//               checks on grants, hazards, backpressure and aging.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enigma_arb;
  import enigma_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  enigma_arb_if bus ();

  enigma_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    tag_t              tag;
    logic [QOS_W-1:0]  qos;
    logic [DATA_W-1:0] payload;
  } beat_t;

  beat_t             exp_q[$];
  int                n_total = 0;
  int                n_pass  = 0;
  logic [SB_DEPTH-1:0] m_sb;
  logic [CNT_W-1:0]  m_cnt;
  logic              m_err;

  function automatic logic [DATA_W-1:0] rnd_payload();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: compare state from completed edges, then fold in the
  // events that the coming edge will commit.
  always @(negedge clk) begin
    beat_t b;
    logic  hs_a, hs_b;
    if (!rst_n) begin
      m_sb  = '0;
      m_cnt = '0;
      m_err = 1'b0;
      exp_q.delete();
    end else begin
      n_total++;
      if (bus.outstanding_cnt !== m_cnt)
        $display("FAIL mon_cnt: got %0d want %0d", bus.outstanding_cnt, m_cnt);
      else n_pass++;
      n_total++;
      if (bus.rel_err !== m_err)
        $display("FAIL mon_rel_err: got %b want %b", bus.rel_err, m_err);
      else n_pass++;
      n_total++;
      if ((bus.ready_a & bus.ready_b) !== 1'b0)
        $display("FAIL mon_onehot: got ready_a=%b ready_b=%b want not both",
                 bus.ready_a, bus.ready_b);
      else n_pass++;
      if (bus.valid_c && bus.ready_c) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL mon_beat: got id=%h with no beat expected", bus.id_c);
        end else begin
          b = exp_q.pop_front();
          if ({bus.id_c, bus.qos_c, bus.payload_c} !== {b.tag, b.qos, b.payload})
            $display("FAIL mon_beat: got id=%h qos=%h payload=%h want id=%h qos=%h payload=%h",
                     bus.id_c, bus.qos_c, bus.payload_c, b.tag, b.qos, b.payload);
          else n_pass++;
        end
      end
      hs_a = bus.valid_a && bus.ready_a;
      hs_b = bus.valid_b && bus.ready_b;
      if (hs_a) begin
        n_total++;
        if (m_sb[make_tag(PORT_A, bus.id_a)] !== 1'b0)
          $display("FAIL mon_dup_tag_a: got grant of busy tag %h want no grant",
                   make_tag(PORT_A, bus.id_a));
        else n_pass++;
      end
      if (hs_b) begin
        n_total++;
        if (m_sb[make_tag(PORT_B, bus.id_b)] !== 1'b0)
          $display("FAIL mon_dup_tag_b: got grant of busy tag %h want no grant",
                   make_tag(PORT_B, bus.id_b));
        else n_pass++;
      end
      if (bus.release_c) begin
        if (m_sb[bus.releaseid_c]) begin
          m_sb[bus.releaseid_c] = 1'b0;
          m_cnt = m_cnt - 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
      if (hs_a) begin
        m_sb[make_tag(PORT_A, bus.id_a)] = 1'b1;
        m_cnt = m_cnt + 1'b1;
        exp_q.push_back('{make_tag(PORT_A, bus.id_a), bus.qos_a, bus.payload_a});
      end
      if (hs_b) begin
        m_sb[make_tag(PORT_B, bus.id_b)] = 1'b1;
        m_cnt = m_cnt + 1'b1;
        exp_q.push_back('{make_tag(PORT_B, bus.id_b), bus.qos_b, bus.payload_b});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.payload_a = '0; bus.id_a = '0; bus.qos_a = '0; bus.valid_a = 1'b0;
    bus.payload_b = '0; bus.id_b = '0; bus.qos_b = '0; bus.valid_b = 1'b0;
    bus.ready_c = 1'b0; bus.conflict_c = 1'b0;
    bus.release_c = 1'b0; bus.releaseid_c = '0;
  endtask

  task automatic rel(input tag_t t);
    bus.release_c   = 1'b1;
    bus.releaseid_c = t;
    step();
    bus.release_c   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    n_total++;
    if ({bus.valid_c, bus.id_c, bus.qos_c} !== '0)
      $display("FAIL reset_c: got valid=%b id=%h qos=%h want 0", bus.valid_c, bus.id_c, bus.qos_c);
    else n_pass++;
    n_total++;
    if (bus.payload_c !== '0) $display("FAIL reset_payload: got %h want 0", bus.payload_c);
    else n_pass++;
    n_total++;
    if ({bus.ready_a, bus.ready_b} !== 2'b00)
      $display("FAIL reset_ready: got %b want 00", {bus.ready_a, bus.ready_b});
    else n_pass++;
    n_total++;
    if ({bus.outstanding_cnt, bus.rel_err} !== '0)
      $display("FAIL reset_status: got cnt=%0d err=%b want 0", bus.outstanding_cnt, bus.rel_err);
    else n_pass++;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_priority();
    bus.valid_a = 1'b1; bus.id_a = 5'd3; bus.qos_a = 2'd2; bus.payload_a = rnd_payload();
    bus.valid_b = 1'b1; bus.id_b = 5'd3; bus.qos_b = 2'd1; bus.payload_b = rnd_payload();
    bus.ready_c = 1'b1;
    @(negedge clk);
    n_total++;
    if ({bus.ready_a, bus.ready_b} !== 2'b10)
      $display("FAIL prio_grant: got %b want 10", {bus.ready_a, bus.ready_b});
    else n_pass++;
    step();
    bus.valid_a = 1'b0;
    @(negedge clk);
    n_total++;
    if ({bus.valid_c, bus.id_c, bus.ready_b} !== {1'b1, 6'h03, 1'b1})
      $display("FAIL prio_first: got valid=%b id=%h ready_b=%b want 1 03 1",
               bus.valid_c, bus.id_c, bus.ready_b);
    else n_pass++;
    step();
    bus.valid_b = 1'b0;
    @(negedge clk);
    n_total++;
    if ({bus.valid_c, bus.id_c} !== {1'b1, 6'h23})
      $display("FAIL prio_second: got valid=%b id=%h want 1 23", bus.valid_c, bus.id_c);
    else n_pass++;
    step();
    rel(6'h03);
    rel(6'h23);
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    bus.valid_a = 1'b1; bus.qos_a = 2'd1;
    bus.valid_b = 1'b1; bus.qos_b = 2'd1;
    bus.ready_c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.id_a = 5'(10 + i); bus.payload_a = rnd_payload();
      bus.id_b = 5'(20 + i); bus.payload_b = rnd_payload();
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      @(negedge clk);
      n_total++;
      if ({bus.ready_a, bus.ready_b} !== exp_g)
        $display("FAIL rr_grant%0d: got %b want %b", i, {bus.ready_a, bus.ready_b}, exp_g);
      else n_pass++;
      if (i > 0) begin
        n_total++;
        if (bus.valid_c !== 1'b1) $display("FAIL rr_valid_c%0d: got %b want 1", i, bus.valid_c);
        else n_pass++;
      end
      step();
    end
    bus.valid_a = 1'b0; bus.valid_b = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.outstanding_cnt !== 7'd4) $display("FAIL rr_cnt: got %0d want 4", bus.outstanding_cnt);
    else n_pass++;
    step();
    rel(6'h0A); rel(6'h0C); rel(6'h35); rel(6'h37);
  endtask

  task automatic test_id_hazard();
    bus.valid_a = 1'b1; bus.id_a = 5'd5; bus.qos_a = 2'd0; bus.payload_a = rnd_payload();
    bus.ready_c = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.ready_a !== 1'b1) $display("FAIL hazard_first: got %b want 1", bus.ready_a);
    else n_pass++;
    step();
    bus.payload_a = rnd_payload();
    repeat (3) begin
      @(negedge clk);
      n_total++;
      if (bus.ready_a !== 1'b0) $display("FAIL hazard_block: got %b want 0", bus.ready_a);
      else n_pass++;
      step();
    end
    bus.release_c = 1'b1; bus.releaseid_c = 6'h05;
    @(negedge clk);
    n_total++;
    if (bus.ready_a !== 1'b0) $display("FAIL hazard_no_bypass: got %b want 0", bus.ready_a);
    else n_pass++;
    step();
    bus.release_c = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.ready_a !== 1'b1) $display("FAIL hazard_reissue: got %b want 1", bus.ready_a);
    else n_pass++;
    step();
    bus.valid_a = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.outstanding_cnt !== 7'd1) $display("FAIL hazard_cnt: got %0d want 1", bus.outstanding_cnt);
    else n_pass++;
    step();
    rel(6'h05);
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] p;
    p = rnd_payload();
    bus.ready_c = 1'b0;
    bus.valid_a = 1'b1; bus.id_a = 5'd7; bus.qos_a = 2'd1; bus.payload_a = p;
    @(negedge clk);
    n_total++;
    if (bus.ready_a !== 1'b1) $display("FAIL bp_accept: got %b want 1", bus.ready_a);
    else n_pass++;
    step();
    bus.id_a = 5'd8; bus.payload_a = rnd_payload();
    bus.valid_b = 1'b1; bus.id_b = 5'd9; bus.qos_b = 2'd1; bus.payload_b = rnd_payload();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_total++;
      if ({bus.ready_a, bus.ready_b} !== 2'b00)
        $display("FAIL bp_ready%0d: got %b want 00", i, {bus.ready_a, bus.ready_b});
      else n_pass++;
      n_total++;
      if ({bus.valid_c, bus.id_c, bus.payload_c} !== {1'b1, 6'h07, p})
        $display("FAIL bp_hold%0d: got valid=%b id=%h payload=%h want 1 07 %h",
                 i, bus.valid_c, bus.id_c, bus.payload_c, p);
      else n_pass++;
      step();
    end
    bus.conflict_c = 1'b1; bus.ready_c = 1'b1;
    @(negedge clk);
    n_total++;
    if ({bus.ready_a, bus.ready_b} !== 2'b00)
      $display("FAIL conflict_block: got %b want 00", {bus.ready_a, bus.ready_b});
    else n_pass++;
    step();
    @(negedge clk);
    n_total++;
    if ({bus.valid_c, bus.ready_a, bus.ready_b} !== 3'b000)
      $display("FAIL conflict_drain: got valid=%b ready=%b want 0 00",
               bus.valid_c, {bus.ready_a, bus.ready_b});
    else n_pass++;
    step();
    bus.conflict_c = 1'b0; bus.valid_a = 1'b0; bus.valid_b = 1'b0;
    rel(6'h07);
  endtask

  task automatic test_bad_release();
    bus.valid_a = 1'b1; bus.id_a = 5'd2; bus.qos_a = 2'd0; bus.payload_a = rnd_payload();
    bus.ready_c = 1'b1;
    step();
    bus.valid_a = 1'b0;
    rel(6'h10);
    @(negedge clk);
    n_total++;
    if (bus.rel_err !== 1'b1) $display("FAIL bad_rel_err: got %b want 1", bus.rel_err);
    else n_pass++;
    n_total++;
    if (bus.outstanding_cnt !== 7'd1) $display("FAIL bad_rel_cnt: got %0d want 1", bus.outstanding_cnt);
    else n_pass++;
    repeat (3) step();
    @(negedge clk);
    n_total++;
    if (bus.rel_err !== 1'b1) $display("FAIL bad_rel_sticky: got %b want 1", bus.rel_err);
    else n_pass++;
    step();
    rel(6'h02);
  endtask

  task automatic test_aging();
    int                  first_a;
    bit                  pend;
    tag_t                ptag;
    logic [SRC_ID_W-1:0] idb;
    first_a = -1; pend = 1'b0; ptag = '0; idb = '0;
    bus.valid_a = 1'b1; bus.id_a = 5'd1; bus.qos_a = 2'd0; bus.payload_a = rnd_payload();
    bus.valid_b = 1'b1; bus.qos_b = 2'd3;
    bus.ready_c = 1'b1;
    for (int c = 0; c < 100; c++) begin
      bus.release_c = pend; bus.releaseid_c = ptag; pend = 1'b0;
      bus.id_b = idb; bus.payload_b = rnd_payload();
      @(negedge clk);
      if (bus.ready_b) begin
        pend = 1'b1;
        ptag = make_tag(PORT_B, idb);
      end
      if (bus.ready_a && first_a < 0) first_a = c;
      step();
      if (pend) idb = idb + 1'b1;
      if (first_a >= 0) bus.valid_a = 1'b0;
    end
    bus.valid_b = 1'b0; bus.release_c = 1'b0;
    n_total++;
`ifdef ENIGMA_ARB_AGING_EN
    if (first_a != 15) $display("FAIL aging_grant: got cycle %0d want 15", first_a);
    else n_pass++;
`else
    if (first_a != -1) $display("FAIL no_aging_starve: got grant at cycle %0d want none", first_a);
    else n_pass++;
`endif
    if (pend) rel(ptag);
    if (first_a >= 0) rel(make_tag(PORT_A, 5'd1));
  endtask

  task automatic test_drain_and_midreset();
    repeat (3) step();
    @(negedge clk);
    n_total++;
    if (exp_q.size() != 0) $display("FAIL drain_queue: got %0d beats left want 0", exp_q.size());
    else n_pass++;
    step();
    bus.ready_c = 1'b0;
    bus.valid_a = 1'b1; bus.id_a = 5'd4; bus.qos_a = 2'd1; bus.payload_a = rnd_payload();
    step();
    bus.valid_a = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.valid_c !== 1'b1) $display("FAIL mid_pending: got %b want 1", bus.valid_c);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.valid_c, bus.outstanding_cnt} !== '0)
      $display("FAIL mid_reset: got valid=%b cnt=%0d want 0 0", bus.valid_c, bus.outstanding_cnt);
    else n_pass++;
    @(negedge clk);
    step();
    rst_n = 1'b1;
    bus.ready_c = 1'b1;
    repeat (3) step();
    @(negedge clk);
    n_total++;
    if (bus.valid_c !== 1'b0) $display("FAIL mid_after: got %b want 0", bus.valid_c);
    else n_pass++;
    step();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_round_robin();
    test_id_hazard();
    test_backpressure();
    test_bad_release();
    test_aging();
    test_drain_and_midreset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/enigma_arb.md
Name: enigma_arb

Overview:
- Synthesizable two-port QoS arbiter that merges requester ports A and B onto the single enigma buffer output port C.
- Drives port C's valid/ready/payload/id/qos interface and consumes its conflict/release feedback.
- Tracks outstanding 6-bit tagged IDs so the same ID cannot be issued twice before it is released.
- Sits between the two upstream masters and the buffer; registered output stage, one transfer per cycle.

Parameters:
DATA_W, 128, payload width
SRC_ID_W, 5, per-port ID width (C ID is SRC_ID_W+1)
QOS_W, 2, QoS field width; larger value = higher priority
MAX_OUTSTANDING, 64, cap on unreleased IDs (must be <= 2^(SRC_ID_W+1))
STARVE_LIMIT, 15, aging threshold in cycles (used only with ENIGMA_ARB_AGING_EN)

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
payload_a / id_a / qos_a / valid_a  in  128/5/2/1  port A request
ready_a  out  1  port A accept
payload_b / id_b / qos_b / valid_b  in  128/5/2/1  port B request
ready_b  out  1  port B accept
valid_c  out  1  port C request
payload_c / id_c / qos_c  out  128/6/2  port C request fields
ready_c  in  1  port C accept
conflict_c  in  1  downstream hazard: hold off new accepts
release_c  in  1  one ID retired this cycle
releaseid_c  in  6  ID being retired
outstanding_cnt  out  7  number of unreleased IDs
rel_err  out  1  sticky: release of an ID that was not outstanding

Behaviour:
- Reset (async, rst_n=0):
  - valid_c=0; payload_c=0; id_c=0; qos_c=0.
  - ready_a=ready_b=0; outstanding_cnt=0; rel_err=0.
  - Scoreboard cleared; round-robin pointer = A; wait counters = 0.
  - Reset mid-transfer drops any in-flight request, with no recovery.
- Tagged ID: tag_x = {port_bit, id_x}; A=0, B=1.
  - Example: B id 3 -> 6'h23.
- Port x is eligible when all of the following hold:
  - valid_x=1;
  - scoreboard[tag_x]=0, using the registered value (no same-cycle release bypass);
  - conflict_c=0;
  - outstanding_cnt < MAX_OUTSTANDING;
  - the output stage is free, i.e. !valid_c || ready_c.
- Grant rules:
  - Only one eligible port -> it wins.
  - Both eligible -> higher qos wins; equal qos -> the port at the RR pointer wins.
  - RR pointer flips to the other port after any grant.
- ready_x is combinational, equal to grant_x. Handshake on port x occurs when valid_x && ready_x.
- Accept at edge N:
  - valid_c=1 from N+1, with payload_c, tag, and qos registered.
  - scoreboard[tag] set; count +1.
- Output stage:
  - valid_c and its fields stay stable while ready_c=0.
  - valid_c is cleared on handshake unless a new accept happens the same cycle (back-to-back, full throughput).
- conflict_c=1 blocks new accepts only; a pending valid_c still drains.
- Release handling:
  - release_c with scoreboard[releaseid_c]=1 clears the bit; count -1.
  - Accept and valid release in the same cycle leave the count unchanged.
  - Release of an unset ID is ignored for scoreboard and count, and sets rel_err (sticky until reset).
  - Release and accept on the same tag in the same cycle cannot occur, because the accept is blocked by the registered bit.
- Full condition: count == MAX_OUTSTANDING -> ready_a = ready_b = 0 until a release.

Optional Feature:
- ENIGMA_ARB_AGING_EN defined:
  - Each port has a 4-bit-minimum wait counter.
  - The counter increments each cycle the port is valid and eligible but loses; it clears on grant or valid low; it saturates.
  - At STARVE_LIMIT the port overrides QoS and wins, and the counter clears on that grant.
- Undefined: no counters; pure QoS plus round-robin, so a low-QoS port can starve indefinitely.

Decomposition:
- Package enigma_pkg holds:
  - DATA_W, SRC_ID_W, QOS_W, TAG_W=SRC_ID_W+1;
  - enum port_e {PORT_A=0, PORT_B=1};
  - typedef tag_t;
  - a function building a tag from port and id.
- Sub-module enigma_arb_scoreboard contains:
  - the 2^TAG_W bit vector;
  - the outstanding counter;
  - rel_err;
  - set/clear/lookup ports (two lookups: A and B).

Test Plan:
- Priority: A qos=2 id=3 and B qos=1 id=3 valid together, ready_c=1 -> ready_a=1, ready_b=0; next cycle id_c=6'h03; following cycle B accepted, id_c=6'h23.
- Round-robin: both valid, qos=1, distinct IDs, ready_c=1 -> grants A,B,A,B from reset; one valid_c per cycle; count reaches 4.
- ID hazard: A id=5 accepted, then A id=5 again -> ready_a=0 held; release_c=1, releaseid_c=6'h05 at cycle K -> ready_a=1 at K+1; count returns to 1.
- Backpressure: valid_c=1, ready_c=0 for 5 cycles -> payload_c/id_c stable, ready_a=ready_b=0; conflict_c=1 with ready_c=1 -> current beat drains, no new accept.
- Bad release: release_c with releaseid_c=6'h10 never issued -> rel_err=1 and stays 1; outstanding_cnt unchanged.
- Aging: B qos=3 continuous unique IDs, A qos=0 id=1 -> with ENIGMA_ARB_AGING_EN, A granted after 15 lost cycles; without it, ready_a stays 0 for 100 cycles.
